// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi front-end frame sequencing logic.
// Optional feature macro: VITERBI_TAIL_FLUSH_EN (appends zero tail words to each frame).
package viterbi_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    RUN   = 3'd2,
    GAP   = 3'd3,
    TAIL  = 3'd4,
    DONE  = 3'd5
  } frame_state_e;

  // Each 16-bit encoded word carries eight 2-bit symbols
  localparam int SYMS_PER_WORD         = 8;
  localparam int DEFAULT_SIZE_DATA_IN  = 16;
  localparam int DEFAULT_SIZE_DATA_OUT = DEFAULT_SIZE_DATA_IN / SYMS_PER_WORD;

  // Default frame geometry
  localparam int DEFAULT_FRAME_WORDS = 8;
  localparam int DEFAULT_TAIL_WORDS  = 1;

`ifdef VITERBI_TAIL_FLUSH_EN
  localparam bit TAIL_FLUSH_EN = 1'b1;
`else
  localparam bit TAIL_FLUSH_EN = 1'b0;
`endif

  // Number of words the serializer actually sees per frame (payload plus any tail)
  function automatic int frame_words_total(input int frame_words, input int tail_words);
    return frame_words + (TAIL_FLUSH_EN ? tail_words : 0);
  endfunction

endpackage

// File: rtl/piso_frame_ctrl.sv
// Frame sequencer for the 16-to-2 PISO symbol serializer feeding the Viterbi
// branch-metric stage. Pulls FRAME_WORDS words from a valid/ready source, hands
// them one at a time to the serializer and reports frame completion plus a
// symbol count.
// Optional feature macro: VITERBI_TAIL_FLUSH_EN -- when defined, TAIL_WORDS zero
// words are serialized after the payload to terminate the trellis.
module piso_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int SIZE_DATA_IN  = DEFAULT_SIZE_DATA_IN,
  parameter int SIZE_DATA_OUT = DEFAULT_SIZE_DATA_OUT,
  parameter int FRAME_WORDS   = DEFAULT_FRAME_WORDS,
  parameter int TAIL_WORDS    = DEFAULT_TAIL_WORDS
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_frame_start,
  input  logic                    i_word_valid,
  input  logic [SIZE_DATA_IN-1:0] i_word,
  output logic                    o_word_ready,
  output logic                    o_piso_start,
  output logic [SIZE_DATA_IN-1:0] o_piso_data,
  input  logic                    i_piso_valid,
  input  logic                    i_piso_done,
  output logic                    o_busy,
  output logic                    o_frame_done,
  output logic [$clog2(FRAME_WORDS+TAIL_WORDS)-1:0] o_word_idx,
  output logic [$clog2((FRAME_WORDS+TAIL_WORDS)*SIZE_DATA_IN/SIZE_DATA_OUT+1)-1:0] o_sym_cnt
);

  localparam int IDX_W = $clog2(FRAME_WORDS + TAIL_WORDS);
  localparam int SYM_W = $clog2((FRAME_WORDS + TAIL_WORDS) * SIZE_DATA_IN / SIZE_DATA_OUT + 1);

  // Index of the final payload word; GAP compares against it to pick the next phase
  localparam logic [IDX_W-1:0] LAST_PAYLOAD_IDX = IDX_W'(FRAME_WORDS - 1);

`ifdef VITERBI_TAIL_FLUSH_EN
  // Index of the final tail word, i.e. the last word of the whole frame
  localparam logic [IDX_W-1:0] LAST_WORD_IDX =
    IDX_W'(frame_words_total(FRAME_WORDS, TAIL_WORDS) - 1);
`endif

  // Symbol counter sticks at all-ones instead of wrapping
  localparam logic [SYM_W-1:0] SYM_MAX = '1;

  frame_state_e            state_q, state_d;
  logic [SIZE_DATA_IN-1:0] data_q, data_d;
  logic [IDX_W-1:0]        word_idx_q, word_idx_d;
  logic [SYM_W-1:0]        sym_cnt_q, sym_cnt_d;

  // State, data word and counters all return to zero on reset; a partial frame is dropped
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      word_idx_q <= '0;
      sym_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      word_idx_q <= word_idx_d;
      sym_cnt_q  <= sym_cnt_d;
    end
  end

  // Next-state decode: one word per FETCH/RUN/GAP round trip, tail words after the payload
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_frame_start) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (i_word_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (i_piso_done) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (word_idx_q < LAST_PAYLOAD_IDX) begin
          state_d = FETCH;
`ifdef VITERBI_TAIL_FLUSH_EN
        end else if (word_idx_q < LAST_WORD_IDX) begin
          state_d = TAIL;
`endif
        end else begin
          state_d = DONE;
        end
      end
      TAIL: begin
`ifdef VITERBI_TAIL_FLUSH_EN
        if (i_piso_done) begin
          if (word_idx_q < LAST_WORD_IDX) begin
            state_d = GAP;
          end else begin
            state_d = DONE;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath updates: capture the handshaked word, advance the word index, count symbols
  always_comb begin
    data_d     = data_q;
    word_idx_d = word_idx_q;
    sym_cnt_d  = sym_cnt_q;

    if (state_q == IDLE && i_frame_start) begin
      word_idx_d = '0;
      sym_cnt_d  = '0;
    end

    if (state_q == FETCH && i_word_valid) begin
      data_d = i_word;
    end

    if (state_q == GAP && state_d != DONE) begin
      word_idx_d = word_idx_q + IDX_W'(1);
    end

    if (state_q != IDLE && i_piso_valid && sym_cnt_q != SYM_MAX) begin
      sym_cnt_d = sym_cnt_q + SYM_W'(1);
    end
  end

  // Output decode from registered state only, so no input reaches an output combinationally
  always_comb begin
    o_word_ready = 1'b0;
    o_piso_start = 1'b0;
    o_piso_data  = '0;
    o_frame_done = 1'b0;
    o_busy       = (state_q != IDLE);
    unique case (state_q)
      FETCH: begin
        o_word_ready = 1'b1;
      end
      RUN: begin
        o_piso_start = 1'b1;
        o_piso_data  = data_q;
      end
      TAIL: begin
        o_piso_start = 1'b1;
      end
      DONE: begin
        o_frame_done = 1'b1;
      end
      default: begin
        o_word_ready = 1'b0;
      end
    endcase
  end

  assign o_word_idx = word_idx_q;
  assign o_sym_cnt  = sym_cnt_q;

endmodule

// File: tb/tb_piso_frame_ctrl.sv
// Self-checking bench for piso_frame_ctrl with a behavioural serializer and
// upstream word source. Build with or without VITERBI_TAIL_FLUSH_EN.
module tb_piso_frame_ctrl;

  localparam int FW  = 8;
  localparam int TW  = 1;
`ifdef VITERBI_TAIL_FLUSH_EN
  localparam int TOTAL     = FW + TW;
  localparam int FULL_SYMS = 72;
  localparam int FINAL_IDX = 8;
`else
  localparam int TOTAL     = FW;
  localparam int FULL_SYMS = 64;
  localparam int FINAL_IDX = 7;
`endif
  localparam int SYM_LIMIT = 127;
  localparam int MAX_WAIT  = 3000;

  localparam int GAP_NONE  = 0;
  localparam int GAP_FETCH = 1;
  localparam int GAP_TAIL  = 2;
  localparam int GAP_DONE  = 3;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic        word_valid;
  logic [15:0] word;
  logic        word_ready;
  logic        piso_start;
  logic [15:0] piso_data;
  logic        piso_valid;
  logic        piso_done;
  logic        busy;
  logic        frame_done;
  logic [3:0]  word_idx;
  logic [6:0]  sym_cnt;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  int doneBase = 0;

  // Stimulus-side state shared with the source and serializer models
  logic [15:0] srcQ[$];
  logic [15:0] capQ[$];
  int  sentCount = 0;
  int  stallIdx = -1;
  int  stallLen = 0;
  bit  injectDone = 0;
  bit  injectValid = 0;

  piso_frame_ctrl #(
    .SIZE_DATA_IN (16),
    .SIZE_DATA_OUT(2),
    .FRAME_WORDS  (FW),
    .TAIL_WORDS   (TW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_frame_start(frame_start),
    .i_word_valid (word_valid),
    .i_word       (word),
    .o_word_ready (word_ready),
    .o_piso_start (piso_start),
    .o_piso_data  (piso_data),
    .i_piso_valid (piso_valid),
    .i_piso_done  (piso_done),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .o_word_idx   (word_idx),
    .o_sym_cnt    (sym_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Upstream source: presents queued words, optionally withholding valid for stallLen FETCH cycles
  initial begin
    bit prevReady;
    int stallLeft;
    prevReady  = 1'b0;
    stallLeft  = 0;
    word_valid = 1'b0;
    word       = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        word_valid = 1'b0;
        prevReady  = 1'b0;
        stallLeft  = 0;
        continue;
      end
      if (prevReady && word_valid) begin
        void'(srcQ.pop_front());
        sentCount++;
        word_valid = 1'b0;
        stallLeft  = (sentCount == stallIdx) ? stallLen : 0;
      end
      if (stallLeft > 0) begin
        word_valid = 1'b0;
        if (word_ready) stallLeft--;
      end else if (srcQ.size() > 0) begin
        word_valid = 1'b1;
        word       = srcQ[0];
      end else begin
        word_valid = 1'b0;
      end
      prevReady = word_ready;
    end
  end

  // Behavioural serializer: 8 symbol strobes per start, done on the last, re-arms when start drops
  initial begin
    int  symLeft;
    bit  armed;
    symLeft    = 0;
    armed      = 1'b1;
    piso_valid = 1'b0;
    piso_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        piso_valid = 1'b0;
        piso_done  = 1'b0;
        symLeft    = 0;
        armed      = 1'b1;
        continue;
      end
      if (!piso_start) armed = 1'b1;
      if (symLeft == 0 && armed && piso_start) begin
        symLeft = 8;
        armed   = 1'b0;
        capQ.push_back(piso_data);
      end
      if (symLeft > 0) begin
        piso_valid = 1'b1;
        piso_done  = (symLeft == 1);
        symLeft--;
      end else begin
        piso_valid  = injectValid;
        piso_done   = injectDone;
        injectValid = 1'b0;
        injectDone  = 1'b0;
      end
    end
  end

  // Reference model state: expected outputs after the most recent clock edge
  bit          mBusy, mReady, mStart, mFd, mInTail;
  logic [15:0] mData;
  int          mIdx, mSym, mDoneWords, mGap;

  // Advance the expected outputs by one edge using the frame timing rules
  task automatic modelStep();
    bit          nBusy, nReady, nStart, nFd;
    logic [15:0] nData;
    int          nIdx, nSym, nGap;
    if (!rst_n) begin
      mBusy = 0; mReady = 0; mStart = 0; mFd = 0; mInTail = 0;
      mData = '0; mIdx = 0; mSym = 0; mDoneWords = 0; mGap = GAP_NONE;
      return;
    end
    nBusy = mBusy; nReady = mReady; nStart = mStart; nFd = 1'b0;
    nData = mData; nIdx = mIdx; nSym = mSym; nGap = GAP_NONE;
    if (mBusy && piso_valid && mSym < SYM_LIMIT) nSym = mSym + 1;
    if (!mBusy && frame_start) begin
      nBusy = 1; nReady = 1; nSym = 0; nIdx = 0; mDoneWords = 0;
    end
    if (mReady && word_valid) begin
      nReady = 0; nStart = 1; nData = word;
    end
    if (mStart && piso_done) begin
      nStart = 0; nData = '0; mDoneWords++;
      if (mInTail && mDoneWords == TOTAL) nFd = 1;
      else if (mDoneWords < FW)           nGap = GAP_FETCH;
      else if (mDoneWords < TOTAL)        nGap = GAP_TAIL;
      else                                nGap = GAP_DONE;
    end
    case (mGap)
      GAP_FETCH: begin nIdx = mDoneWords; nReady = 1; end
      GAP_TAIL:  begin nIdx = mDoneWords; nStart = 1; nData = '0; mInTail = 1; end
      GAP_DONE:  nFd = 1;
      default:   ;
    endcase
    if (mFd) begin
      nBusy = 0; mInTail = 0;
    end
    mBusy = nBusy; mReady = nReady; mStart = nStart; mFd = nFd;
    mData = nData; mIdx = nIdx; mSym = nSym; mGap = nGap;
  endtask

  // Compare every output against the model shortly after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      modelStep();
      checkOutput("busy",       32'(busy),       32'(mBusy));
      checkOutput("word_ready", 32'(word_ready), 32'(mReady));
      checkOutput("piso_start", 32'(piso_start), 32'(mStart));
      checkOutput("piso_data",  32'(piso_data),  32'(mData));
      checkOutput("frame_done", 32'(frame_done), 32'(mFd));
      checkOutput("word_idx",   32'(word_idx),   32'(mIdx));
      checkOutput("sym_cnt",    32'(sym_cnt),    32'(mSym));
      if (frame_done) doneCount++;
    end
  end

  // Load FW words base+1..base+FW and pulse frame start from IDLE
  task automatic applyStimulus(input logic [15:0] base, input int stallAt, input int stallCycles);
    for (int i = 0; i < FW; i++) srcQ.push_back(base + 16'(i + 1));
    sentCount = 0;
    stallIdx  = stallAt;
    stallLen  = stallCycles;
    capQ.delete();
    doneBase  = doneCount;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic waitFrameDone(input string name);
    int n = 0;
    while (doneCount == doneBase && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("%s_frame_done_seen", name), 32'(doneCount - doneBase), 32'd1);
  endtask

  task automatic checkFrame(input string name, input logic [15:0] base);
    logic [15:0] exp;
    checkOutput($sformatf("%s_sym_total", name), 32'(sym_cnt), 32'(FULL_SYMS));
    checkOutput($sformatf("%s_word_count", name), 32'(capQ.size()), 32'(TOTAL));
    for (int i = 0; i < TOTAL && i < capQ.size(); i++) begin
      exp = (i < FW) ? base + 16'(i + 1) : 16'h0000;
      checkOutput($sformatf("%s_word%0d", name, i), 32'(capQ[i]), 32'(exp));
    end
    checkOutput($sformatf("%s_final_idx", name), 32'(word_idx), 32'(FINAL_IDX));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int d0;
    rst_n       = 1'b0;
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",       32'(busy),       32'd0);
    checkOutput("rst_ready",      32'(word_ready), 32'd0);
    checkOutput("rst_start",      32'(piso_start), 32'd0);
    checkOutput("rst_data",       32'(piso_data),  32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_idx",        32'(word_idx),   32'd0);
    checkOutput("rst_sym",        32'(sym_cnt),    32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] stray symbol strobe while idle");
    injectValid = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_strobe_ignored", 32'(sym_cnt), 32'd0);

    $display("[TB] test 1: plain frame");
    applyStimulus(16'h0000, -1, 0);
    waitFrameDone("t1");
    checkFrame("t1", 16'h0000);
    repeat (4) @(negedge clk);

    $display("[TB] test 2: upstream stall before third word");
    applyStimulus(16'h0010, 2, 5);
    waitFrameDone("t2");
    checkFrame("t2", 16'h0010);
    repeat (4) @(negedge clk);

    $display("[TB] test 3: frame start during RUN");
    applyStimulus(16'h0020, -1, 0);
    d0 = doneBase;
    n = 0;
    while (!piso_start && n < MAX_WAIT) begin @(negedge clk); n++; end
    checkOutput("t3_run_reached", 32'(piso_start), 32'd1);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    waitFrameDone("t3");
    checkFrame("t3", 16'h0020);
    repeat (30) @(negedge clk);
    checkOutput("t3_single_done", 32'(doneCount - d0), 32'd1);
    checkOutput("t3_back_idle",   32'(busy), 32'd0);

    $display("[TB] test 4: spurious serializer done during FETCH");
    applyStimulus(16'h0030, 1, 4);
    n = 0;
    while (!(word_ready && sentCount == 1) && n < MAX_WAIT) begin @(negedge clk); n++; end
    checkOutput("t4_fetch_reached", 32'(word_ready), 32'd1);
    injectDone = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("t4_idx_held",   32'(word_idx),   32'd1);
    checkOutput("t4_still_fetch", 32'(word_ready), 32'd1);
    waitFrameDone("t4");
    checkFrame("t4", 16'h0030);
    repeat (4) @(negedge clk);

    $display("[TB] test 5: reset during fourth word");
    applyStimulus(16'h0040, -1, 0);
    d0 = doneBase;
    n = 0;
    while (capQ.size() < 4 && n < MAX_WAIT) begin @(negedge clk); n++; end
    checkOutput("t5_word4_running", 32'(piso_data), 32'h0044);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_busy",  32'(busy),       32'd0);
    checkOutput("t5_start", 32'(piso_start), 32'd0);
    checkOutput("t5_data",  32'(piso_data),  32'd0);
    checkOutput("t5_idx",   32'(word_idx),   32'd0);
    checkOutput("t5_sym",   32'(sym_cnt),    32'd0);
    repeat (2) @(negedge clk);
    srcQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("t5_no_frame_done", 32'(doneCount - d0), 32'd0);
    applyStimulus(16'h0050, -1, 0);
    waitFrameDone("t5b");
    checkFrame("t5b", 16'h0050);
    repeat (4) @(negedge clk);

    $display("[TB] test 6: back-to-back frames");
    applyStimulus(16'h0060, -1, 0);
    waitFrameDone("t6a");
    checkFrame("t6a", 16'h0060);
    for (int i = 0; i < FW; i++) srcQ.push_back(16'h0070 + 16'(i + 1));
    sentCount = 0;
    stallIdx  = -1;
    @(negedge clk);
    capQ.delete();
    doneBase    = doneCount;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    checkOutput("t6_sym_cleared", 32'(sym_cnt), 32'd0);
    checkOutput("t6_busy",        32'(busy),    32'd1);
    waitFrameDone("t6b");
    checkFrame("t6b", 16'h0070);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
